// File: rtl/fifo_readout_arbiter_if.sv
// fifo_readout_arbiter_if
//   Bundles the producer side (per-channel FWFT flags, data, read strobes and
//   preempt requests) and the consumer side (single FWFT read port plus grant
//   status) of the readout arbiter.
//   master : the surrounding logic (producers and consumer) that drives the arbiter.
//   slave  : the arbiter itself.
interface fifo_readout_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            CH_ENABLE;
  logic [NUM_CH-1:0]            IN_FIFO_EMPTY;
  logic [NUM_CH*DATA_WIDTH-1:0] IN_FIFO_DATA;
  logic [NUM_CH-1:0]            IN_PREEMPT_REQ;
  logic [NUM_CH-1:0]            IN_FIFO_READ;
  logic                         OUT_FIFO_READ;
  logic                         OUT_FIFO_EMPTY;
  logic [DATA_WIDTH-1:0]        OUT_FIFO_DATA;
  logic                         GRANT_VALID;
  logic [IDW-1:0]               GRANT_ID;

  modport master (
    output CH_ENABLE, IN_FIFO_EMPTY, IN_FIFO_DATA, IN_PREEMPT_REQ, OUT_FIFO_READ,
    input  IN_FIFO_READ, OUT_FIFO_EMPTY, OUT_FIFO_DATA, GRANT_VALID, GRANT_ID
  );

  modport slave (
    input  CH_ENABLE, IN_FIFO_EMPTY, IN_FIFO_DATA, IN_PREEMPT_REQ, OUT_FIFO_READ,
    output IN_FIFO_READ, OUT_FIFO_EMPTY, OUT_FIFO_DATA, GRANT_VALID, GRANT_ID
  );
endinterface

// File: rtl/fifo_readout_arbiter.sv
// fifo_readout_arbiter
//   Round-robin arbiter sharing one FWFT consumer port between NUM_CH FWFT
//   producers. A grant is held for up to MAX_BURST words; a producer raising
//   its preempt request jumps the queue at the next word boundary.
//   Ports:
//     BUS_CLK : single clock, rising edge
//     BUS_RST : synchronous active-high reset
//     bus     : fifo_readout_arbiter_if.slave (producer flags/data/strobes,
//               consumer read/empty/data, GRANT_VALID/GRANT_ID)
//
//   state  | meaning
//   IDLE   | no grant; picks the next candidate (preempting ones first)
//   LOCKED | GRANT_ID owns the consumer port until burst end, drain or preempt
module fifo_readout_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input logic BUS_CLK,
  input logic BUS_RST,
  fifo_readout_arbiter_if.slave bus
);
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    last;
  logic [15:0]       burst_cnt;

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] pcand;
  logic [NUM_CH-1:0] g_mask;
  logic              g_drained;
  logic              out_empty;
  logic              rd;
  logic              burst_done;
  logic              preempt;
  logic              release_g;

  // First requester after 'from', wrapping; 'from' itself is searched last.
  function automatic logic [IDW-1:0] pick(input logic [NUM_CH-1:0] req,
                                          input logic [IDW-1:0] from);
    logic [IDW-1:0] res;
    logic           found;
    int             idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(from) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        res   = IDW'(idx);
      end
    end
    return res;
  endfunction

  always_comb begin
    cand   = bus.CH_ENABLE & ~bus.IN_FIFO_EMPTY;
    pcand  = cand & bus.IN_PREEMPT_REQ;
    g_mask = '0;
    g_mask[grant_id] = 1'b1;
    g_drained  = bus.IN_FIFO_EMPTY[grant_id] | ~bus.CH_ENABLE[grant_id];
    // Reset also masks the port so no upstream read can slip through mid-burst.
    out_empty  = BUS_RST | ~grant_valid | g_drained;
    rd         = bus.OUT_FIFO_READ & ~out_empty;
    burst_done = rd & (burst_cnt == 16'(MAX_BURST - 1));
    // Preemption only acts on a word boundary (a read) or when the grant is
    // already dead; a granted channel that is itself preempting keeps its grant.
    preempt    = (|(pcand & ~g_mask)) & ~bus.IN_PREEMPT_REQ[grant_id] & (rd | g_drained);
    release_g  = burst_done | g_drained | preempt;
  end

  assign bus.OUT_FIFO_EMPTY = out_empty;
  assign bus.OUT_FIFO_DATA  = grant_valid ?
                              bus.IN_FIFO_DATA[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.IN_FIFO_READ   = rd ? g_mask : '0;
  assign bus.GRANT_VALID    = grant_valid;
  assign bus.GRANT_ID       = grant_id;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last        <= IDW'(NUM_CH - 1);
      burst_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            grant_id    <= (|pcand) ? pick(pcand, last) : pick(cand, last);
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= LOCKED;
          end
        end
        LOCKED: begin
          if (rd) burst_cnt <= burst_cnt + 16'd1;
          // Releasing always passes through IDLE, giving one bubble between grants.
          if (release_g) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last        <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_readout_arbiter.sv
module tb_fifo_readout_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int MB  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_readout_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  fifo_readout_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus)
  );

  // Producer contents (what the DUT may still read) and scoreboard of words
  // the consumer must still receive, per channel.
  logic [DW-1:0] pq    [NCH][$];
  logic [DW-1:0] exp_q [NCH][$];

  logic [NCH-1:0] en_v  = '1;
  logic [NCH-1:0] pre_v = '0;
  logic           rd_v  = 1'b1;
  logic           rst_v = 1'b1;

  int n_vec  = 0;
  int n_err  = 0;
  int seq_no = 0;
  int last_ch;
  int trace[$];
  int rc[$], rl[$], rg[$];
  int e_ch[$], e_len[$], e_gap[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic load(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      pq[ch].push_back({4'(ch), 28'(seq_no)});
      exp_q[ch].push_back({4'(ch), 28'(seq_no)});
      seq_no++;
    end
  endtask

  function automatic int remaining();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += exp_q[i].size();
    return s;
  endfunction

  // One bus cycle: drive at negedge, sample 1ns later, retire the read that
  // the following posedge will perform.
  task automatic cycle();
    logic [NCH-1:0]    emp;
    logic [NCH*DW-1:0] dat;
    logic [NCH-1:0]    exp_rd;
    int                tag;
    logic              ok;
    @(negedge clk);
    rst                = rst_v;
    bus.CH_ENABLE      = en_v;
    bus.IN_PREEMPT_REQ = pre_v;
    bus.OUT_FIFO_READ  = rd_v;
    for (int i = 0; i < NCH; i++) begin
      emp[i] = (pq[i].size() == 0);
      dat[i*DW +: DW] = emp[i] ? '0 : pq[i][0];
    end
    bus.IN_FIFO_EMPTY = emp;
    bus.IN_FIFO_DATA  = dat;
    #1;
    last_ch = -1;
    exp_rd  = '0;
    if (bus.OUT_FIFO_READ && !bus.OUT_FIFO_EMPTY) begin
      tag = int'(bus.OUT_FIFO_DATA[DW-1:DW-4]);
      ok  = (tag < NCH) && (exp_q[tag].size() > 0);
      chk("word_known", 32'(ok), 32'd1);
      if (ok) begin
        last_ch     = tag;
        exp_rd[tag] = 1'b1;
        chk("data", bus.OUT_FIFO_DATA, exp_q[tag].pop_front());
      end
    end
    chk("in_rd", 32'(bus.IN_FIFO_READ), 32'(exp_rd));
    for (int i = 0; i < NCH; i++)
      if (bus.IN_FIFO_READ[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    trace.push_back(last_ch);
  endtask

  task automatic drain(input string tag, input int budget, input int thr);
    int n = 0;
    while (remaining() > 0 && n < budget) begin
      rd_v = (n % thr == 0);
      cycle();
      n++;
    end
    rd_v = 1'b1;
    repeat (3) cycle();
    chk({tag, "_drain"}, 32'(remaining()), 32'd0);
  endtask

  task automatic wait_words(input string tag, input int n);
    int got = 0;
    int k   = 0;
    while (got < n && k < 50) begin
      cycle();
      if (last_ch >= 0) got++;
      k++;
    end
    chk({tag, "_reach"}, 32'(got), 32'(n));
  endtask

  // Compress the trace into runs of one channel and the idle gaps between them.
  task automatic build_runs();
    int cur = -1;
    int len = 0;
    int g   = 0;
    bit started = 1'b0;
    rc.delete(); rl.delete(); rg.delete();
    foreach (trace[k]) begin
      if (trace[k] < 0) begin
        if (started) g++;
      end else if (started && trace[k] == cur && g == 0) begin
        len++;
      end else begin
        if (started) begin
          rc.push_back(cur); rl.push_back(len); rg.push_back(g);
        end
        cur = trace[k]; len = 1; g = 0; started = 1'b1;
      end
    end
    if (started) begin
      rc.push_back(cur); rl.push_back(len);
    end
  endtask

  task automatic check_runs(input string tag);
    build_runs();
    chk({tag, "_nruns"}, 32'(rc.size()), 32'(e_ch.size()));
    foreach (e_ch[k]) begin
      if (k < rc.size()) begin
        chk({tag, "_run_ch"},  32'(rc[k]), 32'(e_ch[k]));
        chk({tag, "_run_len"}, 32'(rl[k]), 32'(e_len[k]));
      end
    end
    foreach (e_gap[k])
      if (k < rg.size()) chk({tag, "_gap"}, 32'(rg[k]), 32'(e_gap[k]));
  endtask

  task automatic set_exp(input int ch, input int len, input int gap);
    e_ch.push_back(ch);
    e_len.push_back(len);
    if (gap >= 0) e_gap.push_back(gap);
  endtask

  initial begin
    bus.CH_ENABLE      = '1;
    bus.IN_PREEMPT_REQ = '0;
    bus.OUT_FIFO_READ  = 1'b1;
    bus.IN_FIFO_EMPTY  = '1;
    bus.IN_FIFO_DATA   = '0;

    // T1: reset with every channel non-empty and the consumer reading
    for (int ch = 0; ch < NCH; ch++) load(ch, 3);
    repeat (3) cycle();
    chk("t1_in_rd", 32'(bus.IN_FIFO_READ), 32'd0);
    chk("t1_empty", 32'(bus.OUT_FIFO_EMPTY), 32'd1);
    chk("t1_gv",    32'(bus.GRANT_VALID), 32'd0);
    chk("t1_gid",   32'(bus.GRANT_ID), 32'd0);
    chk("t1_data",  bus.OUT_FIFO_DATA, 32'd0);
    for (int i = 0; i < NCH; i++) begin
      pq[i].delete();
      exp_q[i].delete();
    end
    cycle();
    rst_v = 1'b0;
    cycle();

    // T3: round robin, 40 words per channel, bursts of 16
    trace.delete();
    for (int ch = 0; ch < NCH; ch++) load(ch, 40);
    drain("t3", 600, 1);
    e_ch.delete(); e_len.delete(); e_gap.delete();
    for (int k = 0; k < 12; k++)
      set_exp(k % 4, (k < 8) ? 16 : 8, (k < 11) ? ((k < 8) ? 1 : 2) : -1);
    check_runs("t3");

    // T2: single channel, 5 words, constant read
    load(2, 5);
    cycle();
    chk("t2_latency", 32'(last_ch), 32'hffff_ffff);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_ch", 32'(last_ch), 32'd2);
      chk("t2_rd", 32'(bus.IN_FIFO_READ), 32'b0100);
    end
    cycle();
    chk("t2_bubble", 32'(bus.OUT_FIFO_EMPTY), 32'd1);
    cycle();
    chk("t2_gv", 32'(bus.GRANT_VALID), 32'd0);

    // T4: ch2 preempts ch0 while ch0 is mid-burst
    trace.delete();
    load(0, 40); load(1, 40); load(2, 10);
    wait_words("t4", 3);
    pre_v = 4'b0100;
    drain("t4", 600, 1);
    pre_v = '0;
    e_ch.delete(); e_len.delete(); e_gap.delete();
    set_exp(0, 4, 1);  set_exp(2, 10, 2); set_exp(0, 16, 1); set_exp(1, 16, 1);
    set_exp(0, 16, 1); set_exp(1, 16, 1); set_exp(0, 4, 2);  set_exp(1, 8, -1);
    check_runs("t4");

    // T5: disable the granted channel mid-burst
    trace.delete();
    load(1, 10);
    wait_words("t5", 3);
    en_v = 4'b1101;
    load(2, 5);
    cycle();
    chk("t5_empty_same_cycle", 32'(bus.OUT_FIFO_EMPTY), 32'd1);
    chk("t5_no_rd", 32'(bus.IN_FIFO_READ), 32'd0);
    repeat (30) cycle();
    chk("t5_ch1_held", 32'(exp_q[1].size()), 32'd7);
    en_v = '1;
    drain("t5", 100, 1);
    e_ch.delete(); e_len.delete(); e_gap.delete();
    set_exp(1, 3, 2); set_exp(2, 5, -1); set_exp(1, 7, -1);
    check_runs("t5");

    // T6a: throttled consumer, one read every third cycle
    for (int ch = 0; ch < NCH; ch++) load(ch, 10);
    drain("t6_thr", 800, 3);

    // T6b: reset in the middle of a ch2 burst; search restarts at ch0
    load(2, 20);
    wait_words("t6", 5);
    rst_v = 1'b1;
    load(1, 20); load(3, 20);
    cycle();
    chk("t6_rst_rd", 32'(bus.IN_FIFO_READ), 32'd0);
    cycle();
    chk("t6_rst_gv",    32'(bus.GRANT_VALID), 32'd0);
    chk("t6_rst_empty", 32'(bus.OUT_FIFO_EMPTY), 32'd1);
    chk("t6_rst_keep",  32'(exp_q[2].size()), 32'd15);
    rst_v = 1'b0;
    trace.delete();
    drain("t6_rst", 600, 1);
    e_ch.delete(); e_len.delete(); e_gap.delete();
    set_exp(1, 16, 1); set_exp(2, 15, 2); set_exp(3, 16, 1); set_exp(1, 4, 2); set_exp(3, 4, -1);
    check_runs("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
